// File: rtl/xheep_boot_pkg.sv
// Shared types and constants for the X-HEEP boot loader.
// - state_t    : boot loader FSM states
// - obi_req_t  : OBI master request (req/we/be/addr/wdata)
// - obi_resp_t : OBI response as seen by a write-only master (gnt/rvalid)
// - dma_size_f : DMA size code for a beat of the given width
package xheep_boot_pkg;

   localparam int          WORD_W            = 32;
   localparam logic [31:0] SOC_CTRL_ADDR_DEF = 32'h2000_000c;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DMA_REQ,
      S_STREAM,
      S_DRAIN,
      S_EXIT_WR,
      S_EXIT_RSP
   } state_t;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   // Read data is never consumed by this master, so it is not carried.
   typedef struct packed {
      logic gnt;
      logic rvalid;
   } obi_resp_t;

   // log2 of the beat size in bytes: 32->3'b010, 64->3'b011, 128->3'b100
   function automatic logic [2:0] dma_size_f(input int dma_w);
      return 3'($clog2(dma_w / 8));
   endfunction

endpackage

// File: rtl/xheep_beat_serializer.sv
// Holds one DMA beat and hands it out as 32-bit words, lowest word first.
// - load_i/nwords_i/data_i : capture a beat with nwords_i valid words
// - pop_i                  : current word consumed, advance
// - flush_i                : discard remaining words (wins over load/pop)
// - word_o/valid_o/last_o  : current word, word present, it is the last one
// - empty_o                : no word held
module xheep_beat_serializer
   import xheep_boot_pkg::*;
#(
   parameter  int DMA_W = 64,
   localparam int WPB   = DMA_W / WORD_W,
   localparam int NW_W  = $clog2(WPB + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [NW_W-1:0]  nwords_i,
   input  logic [DMA_W-1:0] data_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [31:0]      word_o,
   output logic             valid_o,
   output logic             last_o,
   output logic             empty_o
);

   logic [DMA_W-1:0] beat_q, beat_d;
   logic [NW_W-1:0]  rem_q, rem_d;
   logic [NW_W-1:0]  idx_q, idx_d;

   always_comb begin
      beat_d = beat_q;
      rem_d  = rem_q;
      idx_d  = idx_q;
      if (flush_i) begin
         rem_d = '0;
      end else if (load_i) begin
         // a load may coincide with the pop of the previous last word
         beat_d = data_i;
         rem_d  = nwords_i;
         idx_d  = '0;
      end else if (pop_i && rem_q != '0) begin
         rem_d = rem_q - NW_W'(1);
         idx_d = idx_q + NW_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q <= '0;
         rem_q  <= '0;
         idx_q  <= '0;
      end else begin
         beat_q <= beat_d;
         rem_q  <= rem_d;
         idx_q  <= idx_d;
      end
   end

   assign word_o  = 32'(beat_q >> {idx_q, 5'b0});
   assign valid_o = (rem_q != '0);
   assign last_o  = (rem_q == NW_W'(1));
   assign empty_o = (rem_q == '0);

endmodule

// File: rtl/xheep_boot_loader_dmaw.sv
// Boot loader: pulls an image over the ESP DMA read interface and writes it
// word by word into X-HEEP RAM through the external OBI slave port; a boot
// exit writes 1 to SOC_CTRL to release the CPU.
// - conf_done/trigger_fetch/trigger_boot_exit/abort_i : control
// - fetch_addr_byte/fetch_size_words                  : image placement
// - dma_read_ctrl_* / dma_read_chnl_*                 : DMA read command/data
// - obi_req_o/obi_resp_i                              : OBI write master
// - busy/fetch_done_o/exit_done_o/err_o               : status
module xheep_boot_loader_dmaw
   import xheep_boot_pkg::*;
#(
   parameter int          DMA_W         = 64,
   parameter int          MAX_OUTST     = 2,
   parameter logic [31:0] SOC_CTRL_ADDR = SOC_CTRL_ADDR_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             conf_done,
   input  logic             trigger_fetch,
   input  logic             trigger_boot_exit,
   input  logic             abort_i,
   input  logic [31:0]      fetch_addr_byte,
   input  logic [31:0]      fetch_size_words,
   output logic             dma_read_ctrl_valid,
   input  logic             dma_read_ctrl_ready,
   output logic [31:0]      dma_read_ctrl_data_index,
   output logic [31:0]      dma_read_ctrl_data_length,
   output logic [2:0]       dma_read_ctrl_data_size,
   input  logic             dma_read_chnl_valid,
   output logic             dma_read_chnl_ready,
   input  logic [DMA_W-1:0] dma_read_chnl_data,
   output obi_req_t         obi_req_o,
   input  obi_resp_t        obi_resp_i,
   output logic             busy,
   output logic             fetch_done_o,
   output logic             exit_done_o,
   output logic             err_o
);

   localparam int          WPB     = DMA_W / WORD_W;
   localparam int          WPB_LG  = $clog2(WPB);
   localparam int          NW_W    = $clog2(WPB + 1);
   localparam int          OW      = $clog2(MAX_OUTST + 1);
   localparam logic [31:0] LO_MASK = 32'(WPB - 1);

   state_t      state_q, state_d;
   logic [31:0] base_q, base_d, size_q, size_d, beats_q, beats_d;
   logic [31:0] word_cnt_q, word_cnt_d, beat_cnt_q, beat_cnt_d, ld_words_q, ld_words_d;
   logic [OW-1:0] outst_q, outst_d;
   logic        abrt_q, abrt_d, pend_q, pend_d, err_q, err_d;
   logic        fetch_done_q, fetch_done_d, exit_done_q, exit_done_d;

   logic        trig_f, trig_x, str_req, x_req, gnt, rv, more_beats;
   logic        beat_acc, load, pop, flush;
   logic        buf_valid, buf_last, buf_empty;
   logic [31:0] buf_word, rem_words, beats_w;
   logic [NW_W-1:0] nwords;

   xheep_beat_serializer #(.DMA_W(DMA_W)) u_ser (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load),
      .nwords_i (nwords),
      .data_i   (dma_read_chnl_data),
      .pop_i    (pop),
      .flush_i  (flush),
      .word_o   (buf_word),
      .valid_o  (buf_valid),
      .last_o   (buf_last),
      .empty_o  (buf_empty)
   );

   always_comb begin
      trig_f = conf_done & trigger_fetch;
      trig_x = conf_done & trigger_boot_exit & ~trigger_fetch;
      beats_w = (fetch_size_words >> WPB_LG) + {31'b0, |(fetch_size_words & LO_MASK)};

      // An ungranted request (pend_q) stays up regardless of abort/outstanding.
      str_req = (state_q == S_STREAM) & buf_valid &
                (pend_q | (~abrt_q & (outst_q < OW'(MAX_OUTST))));
      x_req   = (state_q == S_EXIT_WR);
      gnt     = (str_req | x_req) & obi_resp_i.gnt;
      rv      = obi_resp_i.rvalid & (outst_q != '0);
      pop     = str_req & obi_resp_i.gnt;

      more_beats = (beat_cnt_q != beats_q);
      // While aborting, beats are swallowed without touching the buffer.
      dma_read_chnl_ready = (state_q == S_STREAM) & more_beats &
                            (abrt_q | buf_empty | (buf_last & pop));
      beat_acc = dma_read_chnl_valid & dma_read_chnl_ready;
      load     = beat_acc & ~abrt_q;
      flush    = (state_q == S_STREAM) & abrt_q & ~str_req;

      rem_words = size_q - ld_words_q;
      nwords    = (rem_words >= 32'(WPB)) ? NW_W'(WPB) : rem_words[NW_W-1:0];

      obi_req_o       = '0;
      obi_req_o.req   = str_req | x_req;
      obi_req_o.we    = str_req | x_req;
      obi_req_o.be    = (str_req | x_req) ? 4'hF : 4'h0;
      if (str_req) begin
         obi_req_o.addr  = base_q + {word_cnt_q[29:0], 2'b00};
         obi_req_o.wdata = buf_word;
      end else if (x_req) begin
         obi_req_o.addr  = SOC_CTRL_ADDR;
         obi_req_o.wdata = 32'd1;
      end
   end

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      size_d       = size_q;
      beats_d      = beats_q;
      word_cnt_d   = word_cnt_q;
      beat_cnt_d   = beat_cnt_q;
      ld_words_d   = ld_words_q;
      abrt_d       = abrt_q;
      err_d        = err_q;
      pend_d       = str_req & ~obi_resp_i.gnt;
      fetch_done_d = 1'b0;
      exit_done_d  = 1'b0;

      case ({gnt, rv})
         2'b10:   outst_d = outst_q + OW'(1);
         2'b01:   outst_d = outst_q - OW'(1);
         default: outst_d = outst_q;
      endcase
      if (load)     ld_words_d = ld_words_q + 32'(nwords);
      if (beat_acc) beat_cnt_d = beat_cnt_q + 32'd1;
      if (pop)      word_cnt_d = word_cnt_q + 32'd1;

      case (state_q)
         S_IDLE: begin
            if (trig_f) begin
               err_d      = 1'b0;
               base_d     = fetch_addr_byte;
               size_d     = fetch_size_words;
               beats_d    = beats_w;
               word_cnt_d = '0;
               beat_cnt_d = '0;
               ld_words_d = '0;
               abrt_d     = 1'b0;
               if (fetch_addr_byte[1:0] != 2'b00) begin
                  err_d        = 1'b1;
                  fetch_done_d = 1'b1;
               end else if (fetch_size_words == '0) begin
                  fetch_done_d = 1'b1;
               end else begin
                  state_d = S_DMA_REQ;
               end
            end else if (trig_x) begin
               err_d   = 1'b0;
               state_d = S_EXIT_WR;
            end
         end
         S_DMA_REQ: begin
            if (abort_i) abrt_d = 1'b1;
            if (dma_read_ctrl_ready) state_d = S_STREAM;
         end
         S_STREAM: begin
            if (abort_i) abrt_d = 1'b1;
            if (pop && word_cnt_q == size_q - 32'd1) state_d = S_DRAIN;
            else if (abrt_q && !more_beats && !str_req) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (outst_q == '0) begin
               fetch_done_d = 1'b1;
               state_d      = S_IDLE;
            end
         end
         S_EXIT_WR: begin
            if (gnt) state_d = S_EXIT_RSP;
         end
         S_EXIT_RSP: begin
            if (obi_resp_i.rvalid) begin
               exit_done_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         base_q       <= '0;
         size_q       <= '0;
         beats_q      <= '0;
         word_cnt_q   <= '0;
         beat_cnt_q   <= '0;
         ld_words_q   <= '0;
         outst_q      <= '0;
         abrt_q       <= 1'b0;
         pend_q       <= 1'b0;
         err_q        <= 1'b0;
         fetch_done_q <= 1'b0;
         exit_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         size_q       <= size_d;
         beats_q      <= beats_d;
         word_cnt_q   <= word_cnt_d;
         beat_cnt_q   <= beat_cnt_d;
         ld_words_q   <= ld_words_d;
         outst_q      <= outst_d;
         abrt_q       <= abrt_d;
         pend_q       <= pend_d;
         err_q        <= err_d;
         fetch_done_q <= fetch_done_d;
         exit_done_q  <= exit_done_d;
      end
   end

   assign dma_read_ctrl_valid       = (state_q == S_DMA_REQ);
   assign dma_read_ctrl_data_index  = '0;
   assign dma_read_ctrl_data_length = beats_q;
   assign dma_read_ctrl_data_size   = dma_size_f(DMA_W);
   assign busy                      = (state_q != S_IDLE);
   assign fetch_done_o              = fetch_done_q;
   assign exit_done_o               = exit_done_q;
   assign err_o                     = err_q;

endmodule

// File: tb/tb_xheep_boot_loader_dmaw.sv
// Self-checking bench for xheep_boot_loader_dmaw (DMA_W=64, MAX_OUTST=2).
// Behavioural OBI slave and DMA source run on the falling edge; expected
// writes are derived from the image array and the requested base/size.
module tb_xheep_boot_loader_dmaw;
   import xheep_boot_pkg::*;

   localparam int DMA_W = 64;
   localparam int WPB   = 2;
   localparam int MAXO  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic conf_done = 1'b0, trigger_fetch = 1'b0, trigger_boot_exit = 1'b0, abort_i = 1'b0;
   logic [31:0] fetch_addr_byte = '0, fetch_size_words = '0;
   logic dma_read_ctrl_valid, dma_read_ctrl_ready = 1'b0;
   logic [31:0] dma_read_ctrl_data_index, dma_read_ctrl_data_length;
   logic [2:0] dma_read_ctrl_data_size;
   logic dma_read_chnl_valid = 1'b0, dma_read_chnl_ready;
   logic [DMA_W-1:0] dma_read_chnl_data = '0;
   obi_req_t  obi_req;
   obi_resp_t obi_resp = '0;
   logic busy, fetch_done_o, exit_done_o, err_o;

   xheep_boot_loader_dmaw #(.DMA_W(DMA_W), .MAX_OUTST(MAXO)) dut (
      .clk(clk), .rst_n(rst_n), .conf_done(conf_done),
      .trigger_fetch(trigger_fetch), .trigger_boot_exit(trigger_boot_exit), .abort_i(abort_i),
      .fetch_addr_byte(fetch_addr_byte), .fetch_size_words(fetch_size_words),
      .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
      .dma_read_ctrl_data_index(dma_read_ctrl_data_index),
      .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
      .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
      .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
      .dma_read_chnl_data(dma_read_chnl_data),
      .obi_req_o(obi_req), .obi_resp_i(obi_resp),
      .busy(busy), .fetch_done_o(fetch_done_o), .exit_done_o(exit_done_o), .err_o(err_o)
   );

   int checks = 0, failures = 0;

   // responder configuration
   int gnt_stall = 0, rv_dly = 1, ctrl_pct = 100, beat_pct = 100;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        we;
      logic [3:0]  be;
   } wr_t;

   logic [31:0] img [64];
   wr_t wr_q [$];
   int  rv_due [$];
   int  cyc = 0;
   int  outst_m = 0, outst_max = 0, stab_err = 0, stall_cnt = 0;
   int  ctrl_cnt = 0, ctrl_len = 0, beat_idx = 0, beats_tot = 0;
   int  fd_cnt = 0, xd_cnt = 0, fd_cyc = 0, last_rv_cyc = 0;
   logic acc_prev = 1'b0, prev_wait = 1'b0, g_l, rv_l;
   logic [31:0] prev_addr = '0, prev_wdata = '0;

   always @(posedge clk) cyc++;

   // Behavioural OBI slave + DMA source; decisions take effect at the next rise.
   always @(negedge clk) begin
      if (!rst_n) begin
         obi_resp = '0; dma_read_ctrl_ready = 1'b0; dma_read_chnl_valid = 1'b0;
         rv_due.delete(); outst_m = 0; stall_cnt = 0; prev_wait = 1'b0;
         acc_prev = 1'b0; beats_tot = 0; beat_idx = 0;
      end else begin
         rv_l = 1'b0;
         if (rv_due.size() > 0 && rv_due[0] <= cyc) begin
            void'(rv_due.pop_front()); rv_l = 1'b1; last_rv_cyc = cyc;
         end
         g_l = 1'b0;
         if (obi_req.req) begin
            if (prev_wait && (obi_req.addr !== prev_addr || obi_req.wdata !== prev_wdata)) stab_err++;
            if (stall_cnt < gnt_stall) stall_cnt++;
            else begin
               g_l = 1'b1; stall_cnt = 0;
               wr_q.push_back('{obi_req.addr, obi_req.wdata, obi_req.we, obi_req.be});
               rv_due.push_back(cyc + rv_dly);
            end
         end else if (prev_wait) stab_err++;
         prev_wait = obi_req.req & ~g_l; prev_addr = obi_req.addr; prev_wdata = obi_req.wdata;
         obi_resp.gnt = g_l; obi_resp.rvalid = rv_l;
         outst_m = outst_m + int'(g_l) - int'(rv_l);
         if (outst_m > outst_max) outst_max = outst_m;

         dma_read_ctrl_ready = 1'b0;
         if (dma_read_ctrl_valid && $urandom_range(99) < ctrl_pct) begin
            dma_read_ctrl_ready = 1'b1; ctrl_cnt++; ctrl_len = int'(dma_read_ctrl_data_length);
            beats_tot = ctrl_len; beat_idx = 0;
         end
         if (fetch_done_o) begin fd_cnt++; fd_cyc = cyc; end
         if (exit_done_o) xd_cnt++;

         if (acc_prev) beat_idx++;
         if (beat_idx < beats_tot && beat_idx < 32 && $urandom_range(99) < beat_pct) begin
            dma_read_chnl_valid = 1'b1;
            dma_read_chnl_data  = {img[2*beat_idx+1], img[2*beat_idx]};
         end else dma_read_chnl_valid = 1'b0;
         #1 acc_prev = dma_read_chnl_valid & dma_read_chnl_ready;
      end
   end

   task automatic step(); @(negedge clk); #2; endtask

   task automatic new_image();
      foreach (img[i]) img[i] = $urandom;
      wr_q.delete(); outst_max = 0; stab_err = 0;
   endtask

   // Pulse a trigger for one cycle and wait (bounded) for fetch_done_o.
   task automatic run_fetch(input logic [31:0] a, input int sz, input logic with_exit, output logic ok);
      int fd0;
      fd0 = fd_cnt;
      step();
      fetch_addr_byte = a; fetch_size_words = sz; trigger_fetch = 1'b1; trigger_boot_exit = with_exit;
      step();
      trigger_fetch = 1'b0; trigger_boot_exit = 1'b0;
      for (int i = 0; i < 3000 && fd_cnt == fd0; i++) step();
      ok = (fd_cnt != fd0);
      repeat (3) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; conf_done = 1'b1;
      repeat (3) step();
      checks++; if (obi_req !== '0) begin failures++; $display("FAIL reset_obi act=%h exp=0", obi_req); end
      checks++; if ({dma_read_ctrl_valid, dma_read_chnl_ready, busy, fetch_done_o, exit_done_o, err_o} !== 6'b0) begin
         failures++; $display("FAIL reset_flags act=%b exp=000000",
            {dma_read_ctrl_valid, dma_read_chnl_ready, busy, fetch_done_o, exit_done_o, err_o}); end
      checks++; if (dma_read_ctrl_data_size !== 3'b011 || dma_read_ctrl_data_length !== 0 || dma_read_ctrl_data_index !== 0) begin
         failures++; $display("FAIL reset_ctrl act=%b/%0d/%0d exp=011/0/0", dma_read_ctrl_data_size,
            dma_read_ctrl_data_length, dma_read_ctrl_data_index); end
      rst_n = 1'b1;
      repeat (2) step();
   endtask

   // Reference: word i goes to base+4i (mod 2^32) with img[i], full byte enables.
   task automatic test_fetch(input string nm, input logic [31:0] a, input int sz, input int st, input int rd);
      logic ok; int fd0, cc0;
      new_image(); gnt_stall = st; rv_dly = rd;
      fd0 = fd_cnt; cc0 = ctrl_cnt;
      run_fetch(a, sz, 1'b0, ok);
      checks++; if (!ok) begin failures++; $display("FAIL %s_done act=timeout exp=pulse", nm); end
      checks++; if (fd_cnt != fd0 + 1) begin failures++; $display("FAIL %s_pulses act=%0d exp=1", nm, fd_cnt - fd0); end
      checks++; if (ctrl_cnt != cc0 + 1 || ctrl_len != (sz + WPB - 1) / WPB) begin
         failures++; $display("FAIL %s_ctrl act=%0d/%0d exp=1/%0d", nm, ctrl_cnt - cc0, ctrl_len, (sz + WPB - 1) / WPB); end
      checks++; if (wr_q.size() != sz) begin failures++; $display("FAIL %s_nwr act=%0d exp=%0d", nm, wr_q.size(), sz); end
      for (int i = 0; i < wr_q.size() && i < sz; i++) begin
         checks++;
         if (wr_q[i].addr !== a + 32'(4 * i) || wr_q[i].data !== img[i] || wr_q[i].we !== 1'b1 || wr_q[i].be !== 4'hF) begin
            failures++; $display("FAIL %s_wr%0d act=%h:%h exp=%h:%h", nm, i, wr_q[i].addr, wr_q[i].data, a + 32'(4 * i), img[i]);
         end
      end
      checks++; if (outst_max > MAXO || stab_err != 0) begin
         failures++; $display("FAIL %s_obi act=outst%0d/unstable%0d exp=<=%0d/0", nm, outst_max, stab_err, MAXO); end
      checks++; if (fd_cyc <= last_rv_cyc || busy !== 1'b0) begin
         failures++; $display("FAIL %s_order act=done@%0d rv@%0d busy%b exp=done after last rvalid, idle", nm, fd_cyc, last_rv_cyc, busy); end
   endtask

   task automatic test_zero_misalign();
      logic ok; int fd0, cc0;
      new_image(); gnt_stall = 0; rv_dly = 1;
      conf_done = 1'b0; step(); trigger_fetch = 1'b1; step(); step(); trigger_fetch = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL noconf act=busy%b exp=0", busy); end
      conf_done = 1'b1;
      fd0 = fd_cnt; cc0 = ctrl_cnt;
      run_fetch(32'h100, 0, 1'b0, ok);
      checks++; if (!ok || fd_cnt != fd0 + 1 || ctrl_cnt != cc0 || wr_q.size() != 0 || err_o !== 1'b0) begin
         failures++; $display("FAIL size0 act=done%0d ctrl%0d wr%0d err%b exp=1/0/0/0", fd_cnt - fd0, ctrl_cnt - cc0, wr_q.size(), err_o); end
      fd0 = fd_cnt;
      run_fetch(32'h102, 5, 1'b0, ok);
      checks++; if (!ok || fd_cnt != fd0 + 1 || ctrl_cnt != cc0 || wr_q.size() != 0) begin
         failures++; $display("FAIL misalign act=done%0d ctrl%0d wr%0d exp=1/0/0", fd_cnt - fd0, ctrl_cnt - cc0, wr_q.size()); end
      repeat (3) step();
      checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_sticky act=%b exp=1", err_o); end
      run_fetch(32'h100, 0, 1'b0, ok);
      checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL err_clear act=%b exp=0", err_o); end
   endtask

   task automatic test_abort();
      logic ok; int fd0, n;
      new_image(); gnt_stall = 0; rv_dly = 2;
      fd0 = fd_cnt;
      step();
      fetch_addr_byte = 32'h300; fetch_size_words = 16; trigger_fetch = 1'b1;
      step(); trigger_fetch = 1'b0;
      for (int i = 0; i < 500 && wr_q.size() < 3; i++) step();
      abort_i = 1'b1; step(); abort_i = 1'b0;
      for (int i = 0; i < 3000 && fd_cnt == fd0; i++) step();
      repeat (3) step();
      n = wr_q.size();
      checks++; if (n < 3 || n > 4) begin failures++; $display("FAIL abort_nwr act=%0d exp=3..4", n); end
      for (int i = 0; i < n && i < 4; i++) begin
         checks++; if (wr_q[i].addr !== 32'h300 + 32'(4 * i) || wr_q[i].data !== img[i]) begin
            failures++; $display("FAIL abort_wr%0d act=%h:%h exp=%h:%h", i, wr_q[i].addr, wr_q[i].data, 32'h300 + 32'(4 * i), img[i]); end
      end
      checks++; if (beat_idx != 8) begin failures++; $display("FAIL abort_beats act=%0d exp=8", beat_idx); end
      checks++; if (fd_cnt != fd0 + 1 || busy !== 1'b0) begin
         failures++; $display("FAIL abort_done act=%0d busy%b exp=1/0", fd_cnt - fd0, busy); end
      // a later fetch starts cleanly
      test_fetch("after_abort", 32'h500, 3, 0, 1);
   endtask

   task automatic test_fetch_and_exit();
      logic ok; int xd0;
      new_image(); gnt_stall = 1; rv_dly = 2;
      xd0 = xd_cnt;
      run_fetch(32'h200, 3, 1'b1, ok);
      checks++; if (!ok || wr_q.size() != 3 || xd_cnt != xd0) begin
         failures++; $display("FAIL both_fetch act=ok%b wr%0d exit%0d exp=1/3/0", ok, wr_q.size(), xd_cnt - xd0); end
      for (int i = 0; i < wr_q.size(); i++) begin
         checks++; if (wr_q[i].addr !== 32'h200 + 32'(4 * i) || wr_q[i].data !== img[i]) begin
            failures++; $display("FAIL both_wr%0d act=%h:%h exp=%h:%h", i, wr_q[i].addr, wr_q[i].data, 32'h200 + 32'(4 * i), img[i]); end
      end
      wr_q.delete(); rv_dly = 4;
      step(); trigger_boot_exit = 1'b1; step(); trigger_boot_exit = 1'b0;
      for (int i = 0; i < 200 && xd_cnt == xd0; i++) step();
      repeat (3) step();
      checks++; if (xd_cnt != xd0 + 1) begin failures++; $display("FAIL exit_done act=%0d exp=1", xd_cnt - xd0); end
      checks++; if (wr_q.size() != 1 || wr_q[0].addr !== 32'h2000_000c || wr_q[0].data !== 32'd1) begin
         failures++; $display("FAIL exit_wr act=n%0d %h:%h exp=1 2000000c:00000001", wr_q.size(),
            wr_q.size() ? wr_q[0].addr : 32'h0, wr_q.size() ? wr_q[0].data : 32'h0); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL exit_idle act=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      int fd0;
      new_image(); gnt_stall = 2; rv_dly = 3;
      fd0 = fd_cnt;
      step();
      fetch_addr_byte = 32'h600; fetch_size_words = 16; trigger_fetch = 1'b1;
      step(); trigger_fetch = 1'b0;
      for (int i = 0; i < 500 && wr_q.size() < 4; i++) step();
      #1 rst_n = 1'b0;
      #1;
      checks++; if (obi_req !== '0 || {dma_read_ctrl_valid, dma_read_chnl_ready, busy, fetch_done_o, err_o} !== 5'b0) begin
         failures++; $display("FAIL mid_reset act=%h/%b exp=0/00000", obi_req,
            {dma_read_ctrl_valid, dma_read_chnl_ready, busy, fetch_done_o, err_o}); end
      repeat (3) step();
      rst_n = 1'b1;
      repeat (2) step();
      checks++; if (fd_cnt != fd0) begin failures++; $display("FAIL mid_reset_pulse act=%0d exp=0", fd_cnt - fd0); end
      test_fetch("restart", 32'h700, 4, 0, 1);
   endtask

   initial begin
      test_reset();
      test_fetch("basic", 32'h100, 5, 0, 1);
      test_fetch("stall", 32'h800, 8, 3, 4);
      test_fetch("deep_rv", 32'h900, 9, 0, 6);
      test_fetch("wrap", 32'hFFFF_FFF8, 5, 1, 2);
      test_zero_misalign();
      test_abort();
      test_fetch_and_exit();
      test_reset_mid();
      for (int k = 0; k < 6; k++) begin
         ctrl_pct = $urandom_range(40, 100); beat_pct = $urandom_range(40, 100);
         test_fetch("rand", {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom_range(1, 20),
                    $urandom_range(0, 3), $urandom_range(1, 5));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
